// File: rtl/byte_pack_pkg.sv
// Shared types and constants for the byte-to-half-word packing writer.
package byte_pack_pkg;

  // Half-word address width the entry type is built with; the writer
  // refuses to elaborate with any other ADDR_W.
  localparam int ADDR_W_PKG = 24;

  // Byte lane selected by byte address bit 0.
  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  // One packed half-word write as it travels through the FIFO.
  typedef struct packed {
    logic [ADDR_W_PKG-1:0] waddr;
    logic [15:0]           data;
    logic [1:0]            be;
  } hw_entry_t;

  // Place a byte on its lane of a half-word; the other lane is zero.
  function automatic logic [15:0] lane_data(input logic lane, input logic [7:0] b);
    return (lane == LANE_HI) ? {b, 8'h00} : {8'h00, b};
  endfunction

  // One-hot byte enable for a lane.
  function automatic logic [1:0] lane_be(input logic lane);
    return (lane == LANE_HI) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/byte_pack_writer_fifo.sv
// Generic synchronous FIFO with a combinational head view. Push while full
// is accepted only when a pop happens in the same cycle; otherwise it is
// ignored and the caller decides what to do about the loss.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  logic             pop_fire;
  logic             push_fire;
  logic [DEPTH-1:0] wr_en;

  // A pop frees the slot the same cycle, so a full FIFO still takes a push then.
  assign pop_fire  = pop && (count_reg != '0);
  assign push_fire = push && ((count_reg != FULL_COUNT) || pop_fire);

  // Per-entry write enables decoded from the write pointer.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push_fire && (wr_ptr_reg == PTR_W'(gi));
  end

  // Occupancy follows the push/pop pair of this cycle.
  always_comb begin
    count_next = count_reg;
    case ({push_fire, pop_fire})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage: cleared on reset so the head view reads zero until first use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) mem_reg[i] <= push_data;
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_COUNT);
  assign count = count_reg;

endmodule

// File: rtl/byte_pack_writer.sv
// Packs a byte-per-cycle write stream into 16-bit half-word writes with byte
// enables, buffers them and drains them to a req/ack memory port.
module byte_pack_writer
  import byte_pack_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       in_addr,
  input  logic [7:0]        in_data,
  input  logic              in_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  output logic              mem_wr_req,
  input  logic              mem_wr_ack,
  output logic              busy,
  output logic              overflow
);

  if (ADDR_W != ADDR_W_PKG) begin : g_bad_addr_w
    $error("byte_pack_writer: ADDR_W must equal byte_pack_pkg::ADDR_W_PKG");
  end

  localparam int ENTRY_W = $bits(hw_entry_t);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  // Byte address bits above the half-word address are intentionally ignored.
  if (ADDR_W < 31) begin : g_unused_addr
    logic unused_addr_bits;
    assign unused_addr_bits = ^in_addr[31:ADDR_W+1];
  end

  logic                 lane;
  logic [ADDR_W-1:0]    in_waddr;
  hw_entry_t            new_entry;

  hw_entry_t            pend_reg;
  hw_entry_t            pend_next;
  logic                 pend_valid_reg;
  logic                 pend_valid_next;

  logic                 push_req;
  hw_entry_t            push_entry;
  logic                 pop_req;

  logic [ENTRY_W-1:0]   fifo_head;
  hw_entry_t            head_entry;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [CNT_W-1:0]     fifo_count;

  logic                 overflow_reg;

  assign lane      = in_addr[0];
  assign in_waddr  = in_addr[ADDR_W:1];
  assign new_entry = '{waddr: in_waddr, data: lane_data(lane, in_data), be: lane_be(lane)};

  // Pack decision: at most one push per cycle plus the next pending state.
  always_comb begin
    push_req        = 1'b0;
    push_entry      = pend_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    if (in_wr) begin
      if (!pend_valid_reg) begin
        pend_next       = new_entry;
        pend_valid_next = 1'b1;
      end else if ((pend_reg.waddr == in_waddr) && !pend_reg.be[lane]) begin
        // Second half of the pair: complete the word and send it straight on.
        push_req         = 1'b1;
        push_entry.be    = 2'b11;
        push_entry.data  = (lane == LANE_HI) ? {in_data, pend_reg.data[7:0]}
                                             : {pend_reg.data[15:8], in_data};
        pend_valid_next  = 1'b0;
      end else begin
        // Different word, or the lane is taken: retire pending as a partial.
        push_req        = 1'b1;
        pend_next       = new_entry;
        pend_valid_next = 1'b1;
      end
    end else if (pend_valid_reg) begin
      // Idle cycle: flush whatever is pending so writes never linger.
      push_req        = 1'b1;
      pend_valid_next = 1'b0;
    end
  end

  // Pending half-word register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
    end else begin
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
    end
  end

  assign pop_req = mem_wr_req && mem_wr_ack;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (push_entry),
    .pop       (pop_req),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Sticky loss flag: a push met a full FIFO with nothing leaving.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (push_req && fifo_full && !pop_req) begin
      overflow_reg <= 1'b1;
    end
  end

  assign head_entry = hw_entry_t'(fifo_head);
  assign mem_addr   = head_entry.waddr;
  assign mem_wdata  = head_entry.data;
  assign mem_be     = head_entry.be;
  assign mem_wr_req = (fifo_count != '0);
  assign busy       = pend_valid_reg || !fifo_empty;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_byte_pack_writer.sv
// Scoreboard bench for byte_pack_writer: expected half-word writes are queued
// as bytes are driven and compared when the memory port accepts a write.
module tb_byte_pack_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_addr;
  logic [7:0]  in_data;
  logic        in_wr;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_wr_req;
  logic        mem_wr_ack;
  logic        busy;
  logic        overflow;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  byte_pack_writer #(.ADDR_W(24), .DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_wr      (in_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_wr_req (mem_wr_req),
    .mem_wr_ack (mem_wr_ack),
    .busy       (busy),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lane_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic void push_exp(input logic [23:0] a, input logic [15:0] d, input logic [1:0] be);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.be   = be;
    exp_q.push_back(e);
  endfunction

  task automatic drive_byte(input logic [31:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    in_wr   = 1'b1;
    in_addr = a;
    in_data = d;
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_wr = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Compare every accepted write against the oldest expectation; unused lanes are masked.
  always @(negedge clk) begin
    if (!reset && mem_wr_req && mem_wr_ack) begin
      exp_t e;
      $display("WRITE addr=%h data=%h be=%b", mem_addr, mem_wdata, mem_be);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("write", 64'({mem_addr, mem_wdata & lane_mask(mem_be), mem_be}),
                       64'({e.addr, e.data & lane_mask(e.be), e.be}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    in_wr      = 1'b0;
    in_addr    = '0;
    in_data    = '0;
    mem_wr_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 64'(mem_wr_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_be", 64'(mem_be), 64'd0);
    reset      = 1'b0;
    mem_wr_ack = 1'b1;

    // Four-byte burst: two full half-words, req two cycles after the first byte.
    push_exp(24'h000080, 16'h2211, 2'b11);
    push_exp(24'h000081, 16'h4433, 2'b11);
    drive_byte(32'h100, 8'h11);
    drive_byte(32'h101, 8'h22);
    check("req_latency_early", 64'(mem_wr_req), 64'd0);
    drive_byte(32'h102, 8'h33);
    check("req_latency", 64'(mem_wr_req), 64'd1);
    drive_byte(32'h103, 8'h44);
    drive_idle(1);
    wait_idle("burst");

    // Lone high-lane byte flushed on the idle cycle.
    push_exp(24'h000102, 16'hAB00, 2'b10);
    drive_byte(32'h205, 8'hAB);
    drive_idle(1);
    wait_idle("flush");

    // Different words back to back: no merge.
    push_exp(24'h000008, 16'h005A, 2'b01);
    push_exp(24'h000010, 16'h00A5, 2'b01);
    drive_byte(32'h010, 8'h5A);
    drive_byte(32'h020, 8'hA5);
    drive_idle(1);
    wait_idle("nomerge");

    // Same lane twice: two partial writes in order.
    push_exp(24'h000018, 16'h0001, 2'b01);
    push_exp(24'h000018, 16'h0002, 2'b01);
    drive_byte(32'h030, 8'h01);
    drive_byte(32'h030, 8'h02);
    drive_idle(1);
    wait_idle("samelane");

    // Stalled memory: 20 pairs, only the 8 oldest survive.
    @(posedge clk);
    #1;
    mem_wr_ack = 1'b0;
    for (int k = 0; k < 20; k++) begin
      logic [7:0] lo;
      logic [7:0] hi;
      lo = 8'(2 * k);
      hi = 8'(2 * k + 1);
      if (k < 8) push_exp(24'h000200 + 24'(k), {hi, lo}, 2'b11);
      drive_byte(32'h400 + 32'(2 * k), lo);
      drive_byte(32'h401 + 32'(2 * k), hi);
    end
    drive_idle(2);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_req", 64'(mem_wr_req), 64'd1);
    check("ovf_head_addr", 64'(mem_addr), 64'h200);
    check("ovf_head_data", 64'(mem_wdata), 64'h0100);
    @(posedge clk);
    #1;
    mem_wr_ack = 1'b1;
    wait_idle("ovf_drain");
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Reset with three queued words and a valid pending byte.
    @(posedge clk);
    #1;
    mem_wr_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_byte(32'h600 + 32'(2 * k), 8'hC0 + 8'(k));
      drive_byte(32'h601 + 32'(2 * k), 8'hD0 + 8'(k));
    end
    drive_byte(32'h700, 8'h77);
    @(posedge clk);
    #1;
    in_wr = 1'b0;
    check("pre_rst_busy", 64'(busy), 64'd1);
    check("pre_rst_req", 64'(mem_wr_req), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_req", 64'(mem_wr_req), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    mem_wr_ack = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_req", 64'(mem_wr_req), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
